// File: rtl/memory_sequencer.sv
// Memory sequencer: single-word read/write and multi-word block copy against a
// word-addressed memory with a one-cycle read latency.
module memory_sequencer #(
    parameter logic [15:0] ADDR_MAX = 16'hFFFE
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [15:0] AddrA,
    input  logic [15:0] AddrB,
    input  logic [15:0] WData,
    input  logic [7:0]  Count,
    output logic [15:0] MemData,
    output logic [15:0] MemAddress,
    output logic        MemoryWrite,
    output logic        MemoryRead,
    input  logic [15:0] MemOutput,
    input  logic        MemOverflow,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] RData
);

    typedef enum logic [2:0] {
        StIdle, StRdAddr, StRdWait, StWr, StCpRd, StCpWait, StCpWr, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        bad_a, bad_b, bad_next;
    logic [16:0] src_nxt, dst_nxt;

    assign bad_a = AddrA[0] | (AddrA > ADDR_MAX);
    assign bad_b = AddrB[0] | (AddrB > ADDR_MAX);

    // Carry out of the 17-bit sum flags a wrap past the top of the address space.
    assign src_nxt  = {1'b0, src_q} + 17'd2;
    assign dst_nxt  = {1'b0, dst_q} + 17'd2;
    assign bad_next = src_nxt[16] | dst_nxt[16] |
                      (src_nxt[15:0] > ADDR_MAX) | (dst_nxt[15:0] > ADDR_MAX);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        MemAddress  = '0;
        MemData     = '0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    src_d   = AddrA;
                    dst_d   = AddrB;
                    wdata_d = WData;
                    cnt_d   = Count;
                    err_d   = 1'b0;
                    unique case (Op)
                        2'b00: begin
                            err_d   = bad_a;
                            state_d = bad_a ? StDone : StRdAddr;
                        end
                        2'b01: begin
                            err_d   = bad_b;
                            state_d = bad_b ? StDone : StWr;
                        end
                        2'b10: begin
                            err_d = bad_a | bad_b;
                            if (bad_a | bad_b || Count == 8'd0) begin
                                state_d = StDone;
                            end else begin
                                state_d = StCpRd;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end
                    endcase
                end
            end
            StRdAddr: begin
                MemoryRead = 1'b1;
                MemAddress = src_q;
                state_d    = StRdWait;
            end
            StRdWait: begin
                MemoryRead = 1'b1;
                MemAddress = src_q;
                rdata_d    = MemOutput;
                if (MemOverflow) err_d = 1'b1;
                state_d    = StDone;
            end
            StWr: begin
                MemoryWrite = 1'b1;
                MemAddress  = dst_q;
                MemData     = wdata_q;
                if (MemOverflow) err_d = 1'b1;
                state_d     = StDone;
            end
            StCpRd: begin
                MemoryRead = 1'b1;
                MemAddress = src_q;
                state_d    = StCpWait;
            end
            StCpWait: begin
                MemoryRead = 1'b1;
                MemAddress = src_q;
                rdata_d    = MemOutput;
                if (MemOverflow) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StCpWr;
                end
            end
            StCpWr: begin
                MemoryWrite = 1'b1;
                MemAddress  = dst_q;
                MemData     = rdata_q;
                src_d       = src_nxt[15:0];
                dst_d       = dst_nxt[15:0];
                cnt_d       = cnt_q - 8'd1;
                if (MemOverflow) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == 8'd1) begin
                    state_d = StDone;
                end else if (bad_next) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StCpRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign Busy  = (state_q != StIdle);
    assign Done  = (state_q == StDone);
    assign Error = err_q;
    assign RData = rdata_q;

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed self-checking bench for memory_sequencer with a small behavioural memory.
module tb_memory_sequencer;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [15:0] AddrA = '0;
    logic [15:0] AddrB = '0;
    logic [15:0] WData = '0;
    logic [7:0]  Count = '0;
    logic [15:0] MemData, MemAddress, RData;
    logic        MemoryWrite, MemoryRead, Busy, Done, Error;
    logic [15:0] MemOutput;
    logic        MemOverflow = 1'b0;

    memory_sequencer dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .Op         (Op),
        .AddrA      (AddrA),
        .AddrB      (AddrB),
        .WData      (WData),
        .Count      (Count),
        .MemData    (MemData),
        .MemAddress (MemAddress),
        .MemoryWrite(MemoryWrite),
        .MemoryRead (MemoryRead),
        .MemOutput  (MemOutput),
        .MemOverflow(MemOverflow),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error),
        .RData      (RData)
    );

    always #5 CLK = ~CLK;

    // Memory: word i preloads to 0x1000+i, except word 2 (address 0x0004) = 0x1145.
    logic [15:0] mem [0:255];
    logic [15:0] wr_addr_log [0:63];
    logic [15:0] wr_data_log [0:63];
    logic [15:0] last_rd_addr = '0;
    int rd_n = 0, wr_n = 0, both_n = 0, idle_strobe_n = 0;

    always @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
            mem[2]    <= 16'h1145;
            MemOutput <= '0;
        end else begin
            if (MemoryRead)  MemOutput <= mem[MemAddress[8:1]];
            if (MemoryWrite) mem[MemAddress[8:1]] <= MemData;
        end
        if (MemoryRead) begin
            rd_n++;
            last_rd_addr = MemAddress;
        end
        if (MemoryWrite) begin
            wr_addr_log[wr_n % 64] = MemAddress;
            wr_data_log[wr_n % 64] = MemData;
            wr_n++;
        end
        if (MemoryRead && MemoryWrite) both_n++;
        if ((!Busy || Done) && (MemoryRead || MemoryWrite)) idle_strobe_n++;
    end

    int n_total = 0;
    int n_pass  = 0;
    int rd0, wr0, lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one operation; lat = number of rising edges from the Start-sampling edge
    // (counted as 1) until Done is seen. Bounded at 100.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] wd, input logic [7:0] cnt, input int ovf_at,
                          input int pulse_at, output int lat_o);
        rd0 = rd_n;
        wr0 = wr_n;
        @(negedge CLK);
        Op = op; AddrA = a; AddrB = b; WData = wd; Count = cnt; Start = 1'b1;
        @(negedge CLK);
        lat_o = 1;
        Start = (pulse_at == 1);
        MemOverflow = (ovf_at == 1);
        if (pulse_at == 1) Op = 2'b01;
        while (!Done && lat_o < 100) begin
            @(negedge CLK);
            lat_o++;
            Start = (pulse_at == lat_o);
            MemOverflow = (ovf_at == lat_o);
        end
        Start = 1'b0;
        MemOverflow = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_strobes", {30'd0, MemoryRead, MemoryWrite}, 0);
        check("rst_addr_data", {MemAddress, MemData}, 0);
        check("rst_err_rdata", {15'd0, Error, RData}, 0);
        Reset = 1'b0;

        // Read 0x0004
        run_op(2'b00, 16'h0004, 16'h0000, 16'h0000, 8'd0, 0, 0, lat);
        check("rd_latency", 32'(lat), 3);
        check("rd_strobes", 32'(rd_n - rd0), 2);
        check("rd_addr", 32'(last_rd_addr), 32'h0004);
        check("rd_rdata", 32'(RData), 32'h1145);
        check("rd_err", 32'(Error), 0);
        check("rd_no_write", 32'(wr_n - wr0), 0);

        // Write 0xBEEF to 0x00A0
        run_op(2'b01, 16'h0000, 16'h00A0, 16'hBEEF, 8'd0, 0, 0, lat);
        check("wr_latency", 32'(lat), 2);
        check("wr_count", 32'(wr_n - wr0), 1);
        check("wr_addr", 32'(wr_addr_log[wr0 % 64]), 32'h00A0);
        check("wr_data", 32'(wr_data_log[wr0 % 64]), 32'hBEEF);
        check("wr_no_read", 32'(rd_n - rd0), 0);

        // Copy 3 words 0x0010 -> 0x0100
        run_op(2'b10, 16'h0010, 16'h0100, 16'h0000, 8'd3, 0, 0, lat);
        check("cp_latency", 32'(lat), 10);
        check("cp_wr_count", 32'(wr_n - wr0), 3);
        check("cp_rd_count", 32'(rd_n - rd0), 6);
        check("cp_w0", {wr_addr_log[wr0 % 64], wr_data_log[wr0 % 64]}, 32'h0100_1008);
        check("cp_w1", {wr_addr_log[(wr0 + 1) % 64], wr_data_log[(wr0 + 1) % 64]}, 32'h0102_1009);
        check("cp_w2", {wr_addr_log[(wr0 + 2) % 64], wr_data_log[(wr0 + 2) % 64]}, 32'h0104_100A);
        check("cp_err", 32'(Error), 0);
        @(negedge CLK);
        check("cp_rdata_hold", 32'(RData), 32'h100A);
        check("cp_idle", {30'd0, Busy, Done}, 0);

        // Illegal address on read
        run_op(2'b00, 16'hFFFF, 16'h0000, 16'h0000, 8'd0, 0, 0, lat);
        check("err_rd_latency", 32'(lat), 1);
        check("err_rd_flag", 32'(Error), 1);
        check("err_rd_strobes", 32'((rd_n - rd0) + (wr_n - wr0)), 0);
        @(negedge CLK);
        check("err_hold", 32'(Error), 1);

        // Odd write address, then illegal opcode
        run_op(2'b01, 16'h0000, 16'h0003, 16'h1234, 8'd0, 0, 0, lat);
        check("err_wr_odd", {lat[15:0], 15'd0, Error}, {16'd1, 16'd1});
        check("err_wr_strobes", 32'(wr_n - wr0), 0);
        run_op(2'b11, 16'h0004, 16'h0004, 16'h0000, 8'd1, 0, 0, lat);
        check("err_op11", {lat[15:0], 15'd0, Error}, {16'd1, 16'd1});

        // Overflow during RD_WAIT (second cycle after the Start edge)
        run_op(2'b00, 16'h0006, 16'h0000, 16'h0000, 8'd0, 2, 0, lat);
        check("ovf_latency", 32'(lat), 3);
        check("ovf_err", 32'(Error), 1);

        // Copy with Count=0
        run_op(2'b10, 16'h0010, 16'h0100, 16'h0000, 8'd0, 0, 0, lat);
        check("cp0_latency", 32'(lat), 1);
        check("cp0_err", 32'(Error), 0);
        check("cp0_strobes", 32'((rd_n - rd0) + (wr_n - wr0)), 0);

        // Start pulsed (as a write) while a read is busy: must be ignored
        run_op(2'b00, 16'h0008, 16'h0040, 16'h5555, 8'd0, 0, 1, lat);
        check("busy_rd_latency", 32'(lat), 3);
        check("busy_rdata", 32'(RData), 32'h1004);
        check("busy_no_write", 32'(wr_n - wr0), 0);
        @(negedge CLK);
        check("busy_not_queued", 32'(Busy), 0);

        // Copy that walks off the top of the address space after two words
        run_op(2'b10, 16'hFFFC, 16'h0200, 16'h0000, 8'd3, 0, 0, lat);
        check("top_latency", 32'(lat), 7);
        check("top_err", 32'(Error), 1);
        check("top_wr_count", 32'(wr_n - wr0), 2);

        // Reset 4 cycles into a Count=3 copy, then a write on the first edge after Reset falls
        wr0 = wr_n;
        @(negedge CLK);
        Op = 2'b10; AddrA = 16'h0010; AddrB = 16'h0100; Count = 8'd3; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        check("abort_strobes", {30'd0, MemoryRead, MemoryWrite}, 0);
        check("abort_status", {29'd0, Busy, Done, Error}, 0);
        check("abort_bus", {MemAddress, MemData}, 0);
        check("abort_rdata", 32'(RData), 0);
        check("abort_partial_wr", 32'(wr_n - wr0), 1);
        Reset = 1'b0;
        Op = 2'b01; AddrB = 16'h0020; WData = 16'hCAFE; Start = 1'b1;
        wr0 = wr_n;
        @(negedge CLK);
        Start = 1'b0;
        check("post_rst_accept", 32'(Busy), 1);
        @(negedge CLK);
        check("post_rst_done", 32'(Done), 1);
        check("post_rst_write", {wr_addr_log[wr0 % 64], wr_data_log[wr0 % 64]}, 32'h0020_CAFE);
        check("post_rst_wr_count", 32'(wr_n - wr0), 1);

        @(negedge CLK);
        check("never_both_strobes", 32'(both_n), 0);
        check("no_idle_strobes", 32'(idle_strobe_n), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
